// File: rtl/boid_disp_pkg.sv
// Shared constants for the boid display path.
// Holds the screen geometry, the display RAM address width, the boid count,
// and the frame-build sequencer state encoding.
package boid_disp_pkg;

  localparam int unsigned VIDEO_WIDTH         = 640;
  localparam int unsigned VIDEO_HEIGHT        = 480;
  localparam int unsigned PIXEL_ADDRESS_WIDTH = 19;
  localparam int unsigned MAX_BOIDS           = 64;
  localparam int unsigned BITS_FOR_BOIDS      = 6;

  // Frame-build sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StFetch = 3'd2,
    StPlot  = 3'd3,
    StNext  = 3'd4,
    StDone  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/boid_pixel_addr.sv
// Pixel coordinate to display RAM address.
// Purely combinational; addr = py*640 + px done as (py<<9)+(py<<7)+px.
// Ports:
//   px        in   11  pixel x, one bit wider than needed so sums never wrap
//   py        in   10  pixel y, one bit wider than needed so sums never wrap
//   in_bounds out  1   px < VIDEO_WIDTH and py < VIDEO_HEIGHT
//   addr      out  PIXEL_ADDRESS_WIDTH  linear address (only meaningful when in_bounds)
module boid_pixel_addr
  import boid_disp_pkg::*;
(
  input  logic [10:0]                    px,
  input  logic [9:0]                     py,
  output logic                           in_bounds,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] addr
);

  logic [PIXEL_ADDRESS_WIDTH-1:0] px_ext;
  logic [PIXEL_ADDRESS_WIDTH-1:0] py_ext;

  assign px_ext    = PIXEL_ADDRESS_WIDTH'(px);
  assign py_ext    = PIXEL_ADDRESS_WIDTH'(py);
  assign addr      = (py_ext << 9) + (py_ext << 7) + px_ext;
  assign in_bounds = (px < 11'(VIDEO_WIDTH)) && (py < 10'(VIDEO_HEIGHT));

endmodule

// File: rtl/boid_plot_sequencer.sv
// Frame-build sequencer: on a refresh request it strobes a framebuffer clear,
// then walks every boid, reads its (x,y) through the BPU mux and emits one
// write per visible pixel of a SPRITE x SPRITE square. All outputs registered.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   refresh_req    frame rebuild request, sampled each posedge
//   boid_sel       boid index driving the BPU output mux
//   boid_x, boid_y position of the selected boid
//   clear_pulse    one-cycle clear strobe (high during the CLEAR cycle)
//   pix_we         display RAM write enable, pix_addr its address
//   busy           high in every state except IDLE
//   frame_done     one-cycle pulse (the DONE cycle)
//   overrun        sticky; a request arrived while one was already pending
module boid_plot_sequencer
  import boid_disp_pkg::*;
#(
  parameter int unsigned SPRITE = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           refresh_req,
  output logic [BITS_FOR_BOIDS-1:0]      boid_sel,
  input  logic [9:0]                     boid_x,
  input  logic [8:0]                     boid_y,
  output logic                           clear_pulse,
  output logic                           pix_we,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] pix_addr,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun
);

  localparam logic [1:0]                SpriteLast = 2'(SPRITE - 1);
  localparam logic [BITS_FOR_BOIDS-1:0] LastBoid   = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

  seq_state_e                     state_q, state_d;
  logic [BITS_FOR_BOIDS-1:0]      sel_q, sel_d;
  logic [9:0]                     xr_q, xr_d;
  logic [8:0]                     yr_q, yr_d;
  logic [1:0]                     dx_q, dx_d;
  logic [1:0]                     dy_q, dy_d;
  logic                           pending_q, pending_d;
  logic                           overrun_q, overrun_d;
  logic                           clear_q, clear_d;
  logic                           done_q, done_d;
  logic                           busy_q, busy_d;
  logic                           we_q, we_d;
  logic [PIXEL_ADDRESS_WIDTH-1:0] addr_q, addr_d;

  logic [10:0]                    px;
  logic [9:0]                     py;
  logic                           in_bounds;
  logic [PIXEL_ADDRESS_WIDTH-1:0] addr;

  assign px = {1'b0, xr_q} + {9'b0, dx_q};
  assign py = {1'b0, yr_q} + {8'b0, dy_q};

  boid_pixel_addr u_pixel_addr (
    .px        (px),
    .py        (py),
    .in_bounds (in_bounds),
    .addr      (addr)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    xr_d      = xr_q;
    yr_d      = yr_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    we_d      = 1'b0;
    addr_d    = addr_q;

    // Requests while busy collapse into one pending; a second one is an overrun.
    if (refresh_req && (state_q != StIdle)) begin
      if (pending_q) overrun_d = 1'b1;
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (refresh_req) begin
          state_d = StClear;
          sel_d   = '0;
        end
      end
      StClear: state_d = StFetch;
      StFetch: begin
        xr_d    = boid_x;
        yr_d    = boid_y;
        dx_d    = '0;
        dy_d    = '0;
        state_d = StPlot;
      end
      StPlot: begin
        we_d = in_bounds;
        if (in_bounds) addr_d = addr;
        if (dx_q == SpriteLast) begin
          dx_d = '0;
          if (dy_q == SpriteLast) state_d = StNext;
          else                    dy_d    = dy_q + 2'd1;
        end else begin
          dx_d = dx_q + 2'd1;
        end
      end
      StNext: begin
        if (sel_q == LastBoid) begin
          sel_d   = '0;
          state_d = StDone;
        end else begin
          sel_d   = sel_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone: begin
        // A request landing in this cycle is treated as already pending.
        pending_d = 1'b0;
        state_d   = (pending_q || refresh_req) ? StClear : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign clear_d = (state_d == StClear);
  assign done_d  = (state_d == StDone);
  assign busy_d  = (state_d != StIdle);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      xr_q      <= '0;
      yr_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      clear_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      xr_q      <= xr_d;
      yr_q      <= yr_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      clear_q   <= clear_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
    end
  end

  assign boid_sel    = sel_q;
  assign clear_pulse = clear_q;
  assign frame_done  = done_q;
  assign busy        = busy_q;
  assign pix_we      = we_q;
  assign pix_addr    = addr_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_boid_plot_sequencer.sv
// Self-checking bench for boid_plot_sequencer: a behavioural BPU position table
// feeds the mux, expected write addresses are queued per frame and popped as
// the DUT issues writes.
module tb_boid_plot_sequencer;

  localparam int SPRITE   = 2;
  localparam int NBOIDS   = 64;
  localparam int FRAMELEN = 2 + NBOIDS * (SPRITE * SPRITE + 2);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        refresh_req = 1'b0;
  logic [5:0]  boid_sel;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic        clear_pulse, pix_we, busy, frame_done, overrun;
  logic [18:0] pix_addr;

  logic [9:0]  bx [NBOIDS];
  logic [8:0]  by [NBOIDS];

  logic [18:0] exp_q[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          nwrites = 0;
  int          addr_bad = 0;
  int          sel_steps = 0;
  int          sel_bad = 0;
  bit          sb_on = 1'b0;
  logic [5:0]  prev_sel = '0;
  logic [18:0] last_addr = '0;

  always #5 clock = ~clock;

  assign boid_x = bx[boid_sel];
  assign boid_y = by[boid_sel];

  boid_plot_sequencer #(.SPRITE(SPRITE)) dut (
    .clock       (clock),
    .reset       (reset),
    .refresh_req (refresh_req),
    .boid_sel    (boid_sel),
    .boid_x      (boid_x),
    .boid_y      (boid_y),
    .clear_pulse (clear_pulse),
    .pix_we      (pix_we),
    .pix_addr    (pix_addr),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  // Write scoreboard and boid_sel walk tracker, sampled on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      prev_sel  = '0;
      last_addr = '0;
    end else begin
      if (boid_sel != prev_sel) begin
        sel_steps++;
        if (boid_sel != prev_sel + 6'd1) sel_bad++;
        prev_sel = boid_sel;
      end
      if (pix_we) begin
        nwrites++;
        if (sb_on) begin
          chk_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL write_order: unexpected write addr %0d, none expected", pix_addr);
          end else begin
            logic [18:0] e;
            e = exp_q.pop_front();
            if (pix_addr !== e)
              $display("FAIL write_order: addr %0d, expected %0d", pix_addr, e);
            else
              pass_cnt++;
          end
        end
        last_addr = pix_addr;
      end else if (pix_addr !== last_addr) begin
        addr_bad++;
      end
    end
  end

  task automatic push_frame();
    for (int b = 0; b < NBOIDS; b++)
      for (int dy = 0; dy < SPRITE; dy++)
        for (int dx = 0; dx < SPRITE; dx++) begin
          int px, py;
          px = int'(bx[b]) + dx;
          py = int'(by[b]) + dy;
          if (px < 640 && py < 480) exp_q.push_back(19'(py * 640 + px));
        end
  endtask

  task automatic set_all(input int x, input int y);
    for (int b = 0; b < NBOIDS; b++) begin
      bx[b] = 10'(x);
      by[b] = 9'(y);
    end
  endtask

  // Runs one complete frame from an idle DUT and checks its shape and writes.
  task automatic run_frame(input string tag);
    int n, nexp;
    exp_q.delete();
    push_frame();
    nexp = exp_q.size();
    nwrites = 0; addr_bad = 0; sel_steps = 0; sel_bad = 0;
    sb_on = 1'b1;
    @(negedge clock) refresh_req = 1'b1;
    @(negedge clock) refresh_req = 1'b0;
    chk_cnt++;
    if (clear_pulse !== 1'b1) $display("FAIL %s_clear: clear_pulse %b, expected 1", tag, clear_pulse);
    else pass_cnt++;
    n = 1;
    while (frame_done !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk_cnt++;
    if (n != FRAMELEN) $display("FAIL %s_length: %0d cycles, expected %0d", tag, n, FRAMELEN);
    else pass_cnt++;
    @(negedge clock);
    chk_cnt++;
    if (busy !== 1'b0 || clear_pulse !== 1'b0)
      $display("FAIL %s_idle: busy %b clear %b, expected 0 0", tag, busy, clear_pulse);
    else pass_cnt++;
    chk_cnt++;
    if (nwrites != nexp || exp_q.size() != 0)
      $display("FAIL %s_writes: %0d writes (%0d unmatched), expected %0d", tag, nwrites,
               exp_q.size(), nexp);
    else pass_cnt++;
    chk_cnt++;
    if (addr_bad != 0) $display("FAIL %s_addr_hold: %0d changes, expected 0", tag, addr_bad);
    else pass_cnt++;
    chk_cnt++;
    if (sel_steps != NBOIDS || sel_bad != 0)
      $display("FAIL %s_boid_sel: %0d steps %0d bad, expected %0d 0", tag, sel_steps, sel_bad,
               NBOIDS);
    else pass_cnt++;
    sb_on = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if ({clear_pulse, pix_we, busy, frame_done, overrun} !== 5'b0 || pix_addr !== '0 ||
        boid_sel !== '0)
      $display("FAIL reset_state: outputs %b addr %0d sel %0d, expected all 0",
               {clear_pulse, pix_we, busy, frame_done, overrun}, pix_addr, boid_sel);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    set_all(10, 20);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL basic_pre: queue %0d, expected 0", exp_q.size());
    else pass_cnt++;
    run_frame("basic");
  endtask

  task automatic test_clipping();
    set_all(10, 20);
    bx[5] = 10'd639;  by[5] = 9'd479;
    bx[7] = 10'd1023; by[7] = 9'd0;
    bx[8] = 10'd100;  by[8] = 9'd200;
    run_frame("clip");
  endtask

  task automatic test_pending();
    int n, clears;
    set_all(10, 20);
    exp_q.delete();
    push_frame();
    push_frame();
    nwrites = 0;
    sb_on = 1'b1;
    @(negedge clock) refresh_req = 1'b1;
    @(negedge clock) refresh_req = 1'b0;
    n = 1;
    while (frame_done !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
      refresh_req = (n == 100 || n == 200);
      if (n == 150) begin
        chk_cnt++;
        if (overrun !== 1'b0) $display("FAIL pend_no_overrun: overrun %b, expected 0", overrun);
        else pass_cnt++;
      end
    end
    refresh_req = 1'b0;
    chk_cnt++;
    if (overrun !== 1'b1) $display("FAIL pend_overrun: overrun %b, expected 1", overrun);
    else pass_cnt++;
    @(negedge clock);
    chk_cnt++;
    if (clear_pulse !== 1'b1 || busy !== 1'b1)
      $display("FAIL pend_restart: clear %b busy %b, expected 1 1", clear_pulse, busy);
    else pass_cnt++;
    n = 1;
    while (frame_done !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk_cnt++;
    if (n != FRAMELEN) $display("FAIL pend_length2: %0d cycles, expected %0d", n, FRAMELEN);
    else pass_cnt++;
    clears = 0;
    repeat (30) begin
      @(negedge clock);
      if (clear_pulse) clears++;
    end
    chk_cnt++;
    if (clears != 0 || busy !== 1'b0)
      $display("FAIL pend_two_frames: %0d extra clears busy %b, expected 0 0", clears, busy);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() != 0 || nwrites != 2 * NBOIDS * SPRITE * SPRITE)
      $display("FAIL pend_writes: %0d writes %0d unmatched, expected %0d 0", nwrites,
               exp_q.size(), 2 * NBOIDS * SPRITE * SPRITE);
    else pass_cnt++;
    sb_on = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    set_all(10, 20);
    @(negedge clock) refresh_req = 1'b1;
    @(negedge clock) refresh_req = 1'b0;
    n = 0;
    while (boid_sel != 6'd30 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    chk_cnt++;
    if (busy !== 1'b1 || pix_we !== 1'b1 || boid_sel !== 6'd30)
      $display("FAIL mid_pre: busy %b we %b sel %0d, expected 1 1 30", busy, pix_we, boid_sel);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if ({clear_pulse, pix_we, busy, frame_done, overrun} !== 5'b0 || pix_addr !== '0 ||
        boid_sel !== '0)
      $display("FAIL mid_async_reset: outputs %b addr %0d sel %0d, expected all 0",
               {clear_pulse, pix_we, busy, frame_done, overrun}, pix_addr, boid_sel);
    else pass_cnt++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    nwrites = 0;
    repeat (20) @(negedge clock);
    chk_cnt++;
    if (nwrites != 0 || busy !== 1'b0)
      $display("FAIL mid_quiet: %0d writes busy %b, expected 0 0", nwrites, busy);
    else pass_cnt++;
    run_frame("restart");
  endtask

  task automatic test_random_frame();
    for (int b = 0; b < NBOIDS; b++) begin
      bx[b] = 10'($urandom_range(0, 700));
      by[b] = 9'($urandom_range(0, 511));
    end
    bx[0] = 10'd638; by[0] = 9'd478;
    run_frame("random");
  endtask

  initial begin
    set_all(0, 0);
    test_reset();
    test_basic();
    test_clipping();
    test_pending();
    test_reset_mid_frame();
    test_random_frame();
    test_random_frame();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
